// File: rtl/m10k_bank_reader.sv
// Read initiator for the banked M10K store: walks a strided row range, reads all
// banks in lockstep and streams each row as one wide vector through a 2-entry FIFO.
module m10k_bank_reader #(
  parameter int N_BANKS        = 16,
  parameter int W              = 8,
  parameter int DEPTH_PER_BANK = 1024,
  parameter int AW             = (DEPTH_PER_BANK <= 1) ? 1 : $clog2(DEPTH_PER_BANK)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [AW-1:0]                    cmd_base,
  input  logic [AW-1:0]                    cmd_stride,
  input  logic [AW:0]                      cmd_count,
  output logic [N_BANKS-1:0]               b_en,
  output logic [N_BANKS*AW-1:0]            b_addr,
  output logic [N_BANKS-1:0]               b_we,
  output logic [N_BANKS*W-1:0]             b_din,
  output logic [N_BANKS*((W+7)/8)-1:0]     b_be,
  input  logic [N_BANKS*W-1:0]             b_dout,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [N_BANKS*W-1:0]             out_data,
  output logic                             out_last,
  output logic                             busy,
  output logic                             done
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH_PER_BANK);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [AW-1:0]        stride_q, stride_d;
  logic [AW:0]          remaining_q, remaining_d;
  logic                 pend_q, pend_d;
  logic                 pend_last_q, pend_last_d;
  logic [1:0]           fifo_cnt_q, fifo_cnt_d;
  logic [N_BANKS*W-1:0] head_data_q, head_data_d;
  logic [N_BANKS*W-1:0] tail_data_q, tail_data_d;
  logic                 head_last_q, head_last_d;
  logic                 tail_last_q, tail_last_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 done_q, done_d;

  logic                 pop;
  logic                 push;
  logic                 issue;
  logic [2:0]           credit_use;
  logic [AW:0]          addr_sum;
  logic [AW:0]          addr_wrap;

  assign pop        = (fifo_cnt_q != 2'd0) && out_ready;
  assign push       = pend_q;
  assign credit_use = {1'b0, fifo_cnt_q} + {2'b0, pend_q} - {2'b0, pop};
  // The issue decision sees this cycle's pop so a row freed now is refilled now,
  // which keeps one row per cycle with only two FIFO slots behind the read latency.
  assign issue      = (state_q == RUN) && (credit_use < 3'd2);

  assign addr_sum  = {1'b0, addr_q} + {1'b0, stride_q};
  assign addr_wrap = (addr_sum >= DEPTH_W) ? (addr_sum - DEPTH_W) : addr_sum;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    remaining_d = remaining_q;
    pend_d      = issue;
    pend_last_d = issue && (remaining_q == (AW+1)'(1));
    fifo_cnt_d  = fifo_cnt_q;
    head_data_d = head_data_q;
    tail_data_d = tail_data_q;
    head_last_d = head_last_q;
    tail_last_d = tail_last_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d      = cmd_base;
          stride_d    = cmd_stride;
          remaining_d = cmd_count;
          if (cmd_count == '0) done_d = 1'b1;
          else                 state_d = RUN;
        end
      end
      RUN: begin
        if (issue) begin
          addr_d      = addr_wrap[AW-1:0];
          remaining_d = remaining_q - (AW+1)'(1);
          if (remaining_q == (AW+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    unique case ({push, pop})
      2'b10: begin
        if (fifo_cnt_q == 2'd0) begin
          head_data_d = b_dout;
          head_last_d = pend_last_q;
        end else begin
          tail_data_d = b_dout;
          tail_last_d = pend_last_q;
        end
        fifo_cnt_d = fifo_cnt_q + 2'd1;
      end
      2'b01: begin
        head_data_d = tail_data_q;
        head_last_d = tail_last_q;
        fifo_cnt_d  = fifo_cnt_q - 2'd1;
      end
      2'b11: begin
        if (fifo_cnt_q == 2'd1) begin
          head_data_d = b_dout;
          head_last_d = pend_last_q;
        end else begin
          head_data_d = tail_data_q;
          head_last_d = tail_last_q;
          tail_data_d = b_dout;
          tail_last_d = pend_last_q;
        end
      end
      default: ;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      remaining_q <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      fifo_cnt_q  <= 2'd0;
      head_data_q <= '0;
      tail_data_q <= '0;
      head_last_q <= 1'b0;
      tail_last_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      remaining_q <= remaining_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      fifo_cnt_q  <= fifo_cnt_d;
      head_data_q <= head_data_d;
      tail_data_q <= tail_data_d;
      head_last_q <= head_last_d;
      tail_last_q <= tail_last_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && !pop && (fifo_cnt_q == 2'd2)));
  end

  for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_lane
    assign b_en[gi]                = issue;
    assign b_addr[gi*AW +: AW]     = addr_q;
    assign b_we[gi]                = 1'b0;
    assign b_din[gi*W +: W]        = '0;
    assign b_be[gi*((W+7)/8) +: ((W+7)/8)] = '0;
  end

  assign cmd_ready = cmd_ready_q;
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign out_data  = head_data_q;
  assign out_last  = head_last_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_m10k_bank_reader.sv
module tb_m10k_bank_reader;

  localparam int N     = 16;
  localparam int W     = 8;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int BEW   = (W+7)/8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [AW-1:0]     cmd_base = '0;
  logic [AW-1:0]     cmd_stride = '0;
  logic [AW:0]       cmd_count = '0;
  logic [N-1:0]      b_en;
  logic [N*AW-1:0]   b_addr;
  logic [N-1:0]      b_we;
  logic [N*W-1:0]    b_din;
  logic [N*BEW-1:0]  b_be;
  logic [N*W-1:0]    b_dout = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [N*W-1:0]    out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] mem [N][DEPTH];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  m10k_bank_reader #(.N_BANKS(N), .W(W), .DEPTH_PER_BANK(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_count(cmd_count),
    .b_en(b_en), .b_addr(b_addr), .b_we(b_we), .b_din(b_din), .b_be(b_be),
    .b_dout(b_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (b_en[i]) b_dout[i*W +: W] <= mem[i][b_addr[i*AW +: AW]];
  end

  task automatic run_cmd(input int base, input int stride, input int count, input int mode);
    logic [N*W-1:0]  exp_rows[$];
    int              exp_addrs[$];
    logic [N*W-1:0]  row;
    logic [N*AW-1:0] addr_all;
    logic [3:0]      pat;
    int a, issued, popped, last_pop_c, done_c, first_valid_c;
    bit prev_stall;
    pat = 4'b1001;
    issued = 0; popped = 0; last_pop_c = -1; done_c = -1; first_valid_c = -1; prev_stall = 0;
    for (int k = 0; k < count; k++) begin
      a = (base + k * stride) % DEPTH;
      exp_addrs.push_back(a);
      for (int i = 0; i < N; i++) row[i*W +: W] = mem[i][a];
      exp_rows.push_back(row);
    end

    cmd_valid  = 1'b1;
    cmd_base   = AW'(base);
    cmd_stride = AW'(stride);
    cmd_count  = (AW+1)'(count);
    out_ready  = 1'b1;
    @(negedge clk);
    chk("cmd_ready_accept", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    cmd_base   = AW'($urandom);
    cmd_stride = AW'($urandom);
    cmd_count  = (AW+1)'($urandom);

    for (int c = 1; c <= 400; c++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[c % 4];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (b_en != '0) begin
        chk("b_en_lanes", b_en, {N{1'b1}});
        if (exp_addrs.size() == 0) begin
          chk("extra_issue", exp_addrs.size() > 0, 1'b1);
        end else begin
          a = exp_addrs.pop_front();
          for (int i = 0; i < N; i++) addr_all[i*AW +: AW] = AW'(a);
          chk("b_addr", b_addr, addr_all);
        end
        issued++;
        chk("outstanding_le3", (issued - popped) <= 3, 1'b1);
      end
      if (prev_stall) chk("stall_hold_valid", out_valid, 1'b1);
      if (out_valid) begin
        if (first_valid_c < 0) first_valid_c = c;
        if (exp_rows.size() == 0) begin
          chk("extra_row", exp_rows.size() > 0, 1'b1);
        end else begin
          chk("out_data", out_data, exp_rows[0]);
          chk("out_last", out_last, exp_rows.size() == 1);
          if (out_ready) begin
            void'(exp_rows.pop_front());
            popped++;
            if (exp_rows.size() == 0) last_pop_c = c;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      chk("busy", busy, (count > 0) && !done);
      if (done) begin
        done_c = c;
        chk("cmd_ready_at_done", cmd_ready, 1'b1);
      end
      @(posedge clk); #1;
      if (done_c > 0) break;
    end

    n_tests++;
    if (done_c < 0) begin
      n_fail++;
      $error("FAIL done_timeout base=%0d stride=%0d count=%0d: no done within 400 cycles",
             base, stride, count);
    end

    chk("rows_left", exp_rows.size(), 0);
    chk("rows_issued", issued, count);
    chk("done_cycle", done_c, (count == 0) ? 1 : last_pop_c + 1);
    if (mode == 0 && count > 0) begin
      chk("first_valid_cycle", first_valid_c, 3);
      chk("last_row_cycle", last_pop_c, 2 + count);
    end
    $display("[TB] cmd base=%0d stride=%0d count=%0d mode=%0d rows=%0d done_at=T+%0d",
             base, stride, count, mode, popped, done_c);
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < DEPTH; j++) mem[i][j] = W'(i * 16 + j);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_b_en", b_en, '0);
    chk("rst_b_addr", b_addr, '0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("tied_b_we", b_we, '0);
    chk("tied_b_din", b_din, '0);
    chk("tied_b_be", b_be, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_cmd(0, 1, 4, 0);
    run_cmd(1022, 1, 4, 0);

    for (int i = 0; i < N; i++)
      for (int j = 0; j < DEPTH; j++) mem[i][j] = W'($urandom);

    run_cmd($urandom_range(0, DEPTH-1), $urandom_range(1, 40), 8, 1);
    run_cmd($urandom_range(0, DEPTH-1), 3, 0, 0);
    run_cmd(5, 0, 3, 0);

    cmd_valid = 1'b1; cmd_base = AW'(100); cmd_stride = AW'(1); cmd_count = (AW+1)'(8);
    out_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 1'b0);
    chk("mid_rst_b_en", b_en, '0);
    chk("mid_rst_b_addr", b_addr, '0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_data", out_data, '0);
    chk("mid_rst_out_last", out_last, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    $display("[TB] reset asserted mid-run");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_cmd($urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1), 2, 0);

    for (int r = 0; r < 4; r++)
      run_cmd($urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1),
              $urandom_range(1, 20), 2);
    run_cmd(DEPTH-1, DEPTH-1, 6, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
